mmu_tlb: RTL and testbench
==========================

Name: mmu_tlb

Overview:
- Joint TLB for the dual-issue MIPS core: 16 fully-associative entries, each mapping an even/odd page pair.
- Responder for the CP0 TLB interface. Consumes CP0 index/entryhi/entrylo0/entrylo1 on tlbwi, and returns tlb_index/tlb_entryhi/tlb_entrylo0/tlb_entrylo1 for tlbp/tlbr.
- Translates fetch and data addresses, and raises d_refill/d_invalid/d_modify plus tlbexc_pc back to CP0.

Parameters:
- TLBNUM, 16, number of entries; index width is log2(TLBNUM)=4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tlbwi_en  in  1  one-cycle pulse: write entry cp0_index[3:0]
- tlbr_en  in  1  one-cycle pulse: read entry cp0_index[3:0]
- tlbp_en  in  1  one-cycle pulse: probe using cp0_entryhi
- cp0_index  in  32  CP0 Index
- cp0_entryhi  in  32  {VPN2[31:13], 5'b0, ASID[7:0]}
- cp0_entrylo0  in  32  {6'b0, PFN[25:6], C[5:3], D[2], V[1], G[0]}
- cp0_entrylo1  in  32  same layout as entrylo0, odd page
- tlb_index  out  32  probe result
- tlb_entryhi  out  32  read result
- tlb_entrylo0  out  32  read result
- tlb_entrylo1  out  32  read result
- inst_req  in  1  fetch lookup valid
- inst_vaddr  in  32  fetch virtual address
- inst_paddr  out  32  fetch physical address
- inst_refill  out  1  fetch miss
- inst_invalid  out  1  fetch hit on V=0 page
- data_req  in  1  data lookup valid
- data_we  in  1  lookup is a store
- data_vaddr  in  32  data virtual address
- data_pc  in  32  PC of the memory instruction
- data_paddr  out  32  data physical address
- data_uncached  out  1  kseg1, or mapped page with C==2
- d_refill  out  1  data miss
- d_invalid  out  1  data hit on V=0 page
- d_modify  out  1  store hit on V=1, D=0 page
- tlbexc_pc  out  32  data_pc of the faulting lookup

Behaviour:
- Entry fields: VPN2[18:0], ASID[7:0], G, and for each half PFN[19:0], C[2:0], D, V.
- Reset: every entry cleared (V=0, D=0, G=0, all fields 0); every output 0.
- Write (tlbwi_en):
  - Entry cp0_index[3:0] is written at the clock edge; cp0_index[31:4] is ignored.
  - The stored G bit is cp0_entrylo0[0] & cp0_entrylo1[0].
- Match rule: entry.VPN2 == vaddr[31:13] and (entry.G or entry.ASID == cp0_entryhi[7:0]).
  - Page select: vaddr[12]=0 uses the even half, 1 uses the odd half.
  - On multiple hits, the lowest index wins.
- Probe (tlbp_en): one cycle after the pulse, tlb_index = {~hit, 27'b0, hit_idx[3:0]}; on a miss the low bits are 0.
- Read (tlbr_en): one cycle after the pulse:
  - tlb_entryhi = {VPN2, 5'b0, ASID}
  - tlb_entrylo0/1 = {6'b0, PFN, C, D, V, G}, with G duplicated into both halves.
- Unmapped segments: vaddr[31:30]==2'b10 (kseg0/kseg1).
  - paddr = {3'b0, vaddr[28:0]}; no exception flags.
  - data_uncached = vaddr[29] (kseg1).
- Mapped segments: paddr = {PFN, vaddr[11:0]}.
- Lookup latency: 1 cycle. Results are registered and reflect the request of the previous cycle.
  - The array is sampled before the edge: a tlbwi in the same cycle as a lookup or probe is not visible to it.
  - It is visible to any lookup one cycle later.
- Exception flags are mutually exclusive, priority refill > invalid > modify.
  - refill = mapped & ~hit
  - invalid = mapped & hit & ~V
  - modify = mapped & hit & V & ~D & data_we
- Each flag is high for exactly one cycle per requesting lookup. With req=0, flags are 0 next cycle and paddr holds.
- tlbexc_pc = data_pc registered with the data lookup, updated on every data_req.
- Fetch and data lookups are independent and may hit the same entry in the same cycle.
- tlbr and tlbp may pulse together; both results update.
- Reset mid-operation: at the next edge all outputs go to 0 and in-flight lookup results are discarded.

Optional Feature:
- Macro TLB_TLBWR_EN.
- With it: adds input tlbwr_en and a 4-bit random register.
  - The register resets to TLBNUM-1 and decrements every cycle, wrapping 0 -> TLBNUM-1.
  - tlbwr_en writes the entry selected by the current random value.
  - If tlbwi_en and tlbwr_en are both high, tlbwi wins.
- Without it: no tlbwr_en port and no random register.

Test Plan:
- Reset, then tlbp with entryhi=32'h0040_0005 -> tlb_index=32'h8000_0000 next cycle; all flags 0.
- tlbwi index=3, entryhi=32'h0040_0005, lo0=32'h0000_0106, lo1=32'h0000_0146; then tlbp same entryhi -> tlb_index=32'h0000_0003. Then tlbr index 3 -> entryhi 32'h0040_0005, lo0 32'h0000_0106, lo1 32'h0000_0146.
- Data load vaddr=32'h0040_0123, ASID 5, after that write -> data_paddr=32'h0000_4123, no flags. Same address with ASID 6 -> d_refill=1 for one cycle, tlbexc_pc=data_pc.
- Store to the odd page vaddr=32'h0040_1010 (lo1 V=1, D=0) -> d_modify=1, d_refill=0, d_invalid=0. With lo1 V=0 -> d_invalid=1 only.
- Fetch inst_vaddr=32'hbfc0_0000 -> inst_paddr=32'h1fc0_0000, no flags. data_vaddr=32'ha000_0010 -> data_uncached=1.
- tlbwi entry 3 and data lookup of the same vaddr in the same cycle, on an empty TLB -> d_refill=1. Same lookup one cycle later -> hit, no flags.

Source files
------------

// File: rtl/mmu_tlb.sv
// mmu_tlb: 16-entry fully-associative joint TLB (even/odd page pairs) with CP0 tlbwi/tlbr/tlbp and fetch/data translation.
// Ports: clk/rst (sync, active-high); tlbwi_en/tlbr_en/tlbp_en + cp0_index/entryhi/entrylo0/entrylo1 in;
//   tlb_index/entryhi/entrylo0/entrylo1 out; inst_req/inst_vaddr -> inst_paddr/inst_refill/inst_invalid;
//   data_req/data_we/data_vaddr/data_pc -> data_paddr/data_uncached/d_refill/d_invalid/d_modify/tlbexc_pc.
// Optional: define TLB_TLBWR_EN to add tlbwr_en and a decrementing random-index register.
module mmu_tlb #(
   parameter int TLBNUM = 16
) (
   input  logic        clk,
   input  logic        rst,
`ifdef TLB_TLBWR_EN
   input  logic        tlbwr_en,
`endif
   input  logic        tlbwi_en,
   input  logic        tlbr_en,
   input  logic        tlbp_en,
   input  logic [31:0] cp0_index,
   input  logic [31:0] cp0_entryhi,
   input  logic [31:0] cp0_entrylo0,
   input  logic [31:0] cp0_entrylo1,
   output logic [31:0] tlb_index,
   output logic [31:0] tlb_entryhi,
   output logic [31:0] tlb_entrylo0,
   output logic [31:0] tlb_entrylo1,
   input  logic        inst_req,
   input  logic [31:0] inst_vaddr,
   output logic [31:0] inst_paddr,
   output logic        inst_refill,
   output logic        inst_invalid,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_vaddr,
   input  logic [31:0] data_pc,
   output logic [31:0] data_paddr,
   output logic        data_uncached,
   output logic        d_refill,
   output logic        d_invalid,
   output logic        d_modify,
   output logic [31:0] tlbexc_pc
);
   localparam int IW = $clog2(TLBNUM);

   logic [18:0] vpn2 [TLBNUM];
   logic [7:0]  asid [TLBNUM];
   logic [19:0] pfn0 [TLBNUM];
   logic [19:0] pfn1 [TLBNUM];
   logic [2:0]  c0   [TLBNUM];
   logic [2:0]  c1   [TLBNUM];
   logic        g    [TLBNUM];
   logic        d0   [TLBNUM];
   logic        d1   [TLBNUM];
   logic        v0   [TLBNUM];
   logic        v1   [TLBNUM];

   logic [TLBNUM-1:0] i_vec, d_vec, p_vec;
   logic [IW-1:0] i_idx, d_idx, p_idx, r_idx, widx;
   logic [19:0] i_pfn, d_pfn;
   logic [2:0] d_c;
   logic i_hit, d_hit, p_hit, i_unm, d_unm, i_v, d_v, d_d, we;
   logic unused;

   assign unused = ^{cp0_index[31:IW], cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26], inst_vaddr[29]};

   // lowest matching index wins
   function automatic logic [IW-1:0] first(input logic [TLBNUM-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int k = TLBNUM - 1; k >= 0; k--)
         if (v[k]) r = IW'(k);
      return r;
   endfunction

   for (genvar e = 0; e < TLBNUM; e++) begin : g_match
      assign i_vec[e] = vpn2[e] == inst_vaddr[31:13] && (g[e] || asid[e] == cp0_entryhi[7:0]);
      assign d_vec[e] = vpn2[e] == data_vaddr[31:13] && (g[e] || asid[e] == cp0_entryhi[7:0]);
      assign p_vec[e] = vpn2[e] == cp0_entryhi[31:13] && (g[e] || asid[e] == cp0_entryhi[7:0]);
   end

   assign i_idx = first(i_vec);
   assign d_idx = first(d_vec);
   assign p_idx = first(p_vec);
   assign i_hit = |i_vec;
   assign d_hit = |d_vec;
   assign p_hit = |p_vec;
   assign i_unm = inst_vaddr[31:30] == 2'b10;
   assign d_unm = data_vaddr[31:30] == 2'b10;
   assign i_pfn = inst_vaddr[12] ? pfn1[i_idx] : pfn0[i_idx];
   assign i_v   = inst_vaddr[12] ? v1[i_idx] : v0[i_idx];
   assign d_pfn = data_vaddr[12] ? pfn1[d_idx] : pfn0[d_idx];
   assign d_v   = data_vaddr[12] ? v1[d_idx] : v0[d_idx];
   assign d_d   = data_vaddr[12] ? d1[d_idx] : d0[d_idx];
   assign d_c   = data_vaddr[12] ? c1[d_idx] : c0[d_idx];
   assign r_idx = cp0_index[IW-1:0];

`ifdef TLB_TLBWR_EN
   logic [IW-1:0] rnd;
   always_ff @(posedge clk)
      rnd <= (rst || rnd == '0) ? IW'(TLBNUM - 1) : rnd - IW'(1);
   assign we   = tlbwi_en | tlbwr_en;
   assign widx = tlbwi_en ? r_idx : rnd;
`else
   assign we   = tlbwi_en;
   assign widx = r_idx;
`endif

   always_ff @(posedge clk)
      if (rst)
         for (int k = 0; k < TLBNUM; k++) begin
            vpn2[k] <= '0;
            asid[k] <= '0;
            pfn0[k] <= '0;
            pfn1[k] <= '0;
            c0[k]   <= '0;
            c1[k]   <= '0;
            g[k]    <= 1'b0;
            d0[k]   <= 1'b0;
            d1[k]   <= 1'b0;
            v0[k]   <= 1'b0;
            v1[k]   <= 1'b0;
         end
      else if (we) begin
         vpn2[widx] <= cp0_entryhi[31:13];
         asid[widx] <= cp0_entryhi[7:0];
         pfn0[widx] <= cp0_entrylo0[25:6];
         pfn1[widx] <= cp0_entrylo1[25:6];
         c0[widx]   <= cp0_entrylo0[5:3];
         c1[widx]   <= cp0_entrylo1[5:3];
         d0[widx]   <= cp0_entrylo0[2];
         d1[widx]   <= cp0_entrylo1[2];
         v0[widx]   <= cp0_entrylo0[1];
         v1[widx]   <= cp0_entrylo1[1];
         g[widx]    <= cp0_entrylo0[0] & cp0_entrylo1[0];
      end

   always_ff @(posedge clk)
      if (rst) begin
         tlb_index     <= '0;
         tlb_entryhi   <= '0;
         tlb_entrylo0  <= '0;
         tlb_entrylo1  <= '0;
         inst_paddr    <= '0;
         inst_refill   <= 1'b0;
         inst_invalid  <= 1'b0;
         data_paddr    <= '0;
         data_uncached <= 1'b0;
         d_refill      <= 1'b0;
         d_invalid     <= 1'b0;
         d_modify      <= 1'b0;
         tlbexc_pc     <= '0;
      end else begin
         inst_refill  <= inst_req & ~i_unm & ~i_hit;
         inst_invalid <= inst_req & ~i_unm & i_hit & ~i_v;
         d_refill     <= data_req & ~d_unm & ~d_hit;
         d_invalid    <= data_req & ~d_unm & d_hit & ~d_v;
         d_modify     <= data_req & ~d_unm & d_hit & d_v & ~d_d & data_we;
         if (inst_req)
            inst_paddr <= i_unm ? {3'b0, inst_vaddr[28:0]} : {i_pfn, inst_vaddr[11:0]};
         if (data_req) begin
            data_paddr    <= d_unm ? {3'b0, data_vaddr[28:0]} : {d_pfn, data_vaddr[11:0]};
            data_uncached <= d_unm ? data_vaddr[29] : d_c == 3'd2;
            tlbexc_pc     <= data_pc;
         end
         if (tlbp_en)
            tlb_index <= {~p_hit, {(31 - IW){1'b0}}, p_idx};
         if (tlbr_en) begin
            tlb_entryhi  <= {vpn2[r_idx], 5'b0, asid[r_idx]};
            tlb_entrylo0 <= {6'b0, pfn0[r_idx], c0[r_idx], d0[r_idx], v0[r_idx], g[r_idx]};
            tlb_entrylo1 <= {6'b0, pfn1[r_idx], c1[r_idx], d1[r_idx], v1[r_idx], g[r_idx]};
         end
      end
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed self-checking bench for mmu_tlb.
module tb_mmu_tlb;
   logic clk = 1'b0;
   logic rst, tlbwi_en, tlbr_en, tlbp_en, inst_req, data_req, data_we;
   logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, inst_vaddr, data_vaddr, data_pc;
   logic [31:0] tlb_index, tlb_entryhi, tlb_entrylo0, tlb_entrylo1, inst_paddr, data_paddr, tlbexc_pc;
   logic inst_refill, inst_invalid, data_uncached, d_refill, d_invalid, d_modify;
`ifdef TLB_TLBWR_EN
   logic tlbwr_en = 1'b0;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mmu_tlb dut (
      .clk(clk), .rst(rst),
`ifdef TLB_TLBWR_EN
      .tlbwr_en(tlbwr_en),
`endif
      .tlbwi_en(tlbwi_en), .tlbr_en(tlbr_en), .tlbp_en(tlbp_en),
      .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
      .tlb_index(tlb_index), .tlb_entryhi(tlb_entryhi), .tlb_entrylo0(tlb_entrylo0), .tlb_entrylo1(tlb_entrylo1),
      .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr),
      .inst_refill(inst_refill), .inst_invalid(inst_invalid),
      .data_req(data_req), .data_we(data_we), .data_vaddr(data_vaddr), .data_pc(data_pc),
      .data_paddr(data_paddr), .data_uncached(data_uncached),
      .d_refill(d_refill), .d_invalid(d_invalid), .d_modify(d_modify), .tlbexc_pc(tlbexc_pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] idx, input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
      cp0_index = idx; cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
      tlbwi_en = 1'b1;
      tick();
      tlbwi_en = 1'b0;
   endtask

   // flag vector order: {inst_refill, inst_invalid, d_refill, d_invalid, d_modify}
   function automatic logic [31:0] flags();
      return {27'b0, inst_refill, inst_invalid, d_refill, d_invalid, d_modify};
   endfunction

   initial begin
      rst = 1'b1; tlbwi_en = 0; tlbr_en = 0; tlbp_en = 0; inst_req = 0; data_req = 0; data_we = 0;
      cp0_index = 0; cp0_entryhi = 0; cp0_entrylo0 = 0; cp0_entrylo1 = 0;
      inst_vaddr = 0; data_vaddr = 0; data_pc = 0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_index", tlb_index, 32'h0);
      chk("reset_dpaddr", data_paddr, 32'h0);
      chk("reset_flags", flags(), 32'h0);

      cp0_entryhi = 32'h0040_0005; tlbp_en = 1'b1;
      tick(); tlbp_en = 1'b0;
      chk("probe_empty", tlb_index, 32'h8000_0000);
      chk("probe_empty_flags", flags(), 32'h0);

      wr(32'hffff_fff3, 32'h0040_0005, 32'h0000_0106, 32'h0000_0146);
      tlbp_en = 1'b1;
      tick(); tlbp_en = 1'b0;
      chk("probe_hit", tlb_index, 32'h0000_0003);
      cp0_index = 3; tlbr_en = 1'b1;
      tick(); tlbr_en = 1'b0;
      chk("read_hi", tlb_entryhi, 32'h0040_0005);
      chk("read_lo0", tlb_entrylo0, 32'h0000_0106);
      chk("read_lo1", tlb_entrylo1, 32'h0000_0146);

      data_req = 1'b1; data_we = 1'b0; data_vaddr = 32'h0040_0123; data_pc = 32'h0000_1000;
      tick();
      chk("load_paddr", data_paddr, 32'h0000_4123);
      chk("load_flags", flags(), 32'h0);
      chk("load_uncached", {31'b0, data_uncached}, 32'h0);
      data_req = 1'b0;
      tick();
      chk("idle_paddr_hold", data_paddr, 32'h0000_4123);
      chk("idle_flags", flags(), 32'h0);
      cp0_entryhi = 32'h0040_0006; data_req = 1'b1; data_pc = 32'h0000_2000;
      tick(); data_req = 1'b0;
      chk("asid_miss_flags", flags(), 32'h4);
      chk("asid_miss_pc", tlbexc_pc, 32'h0000_2000);
      tick();
      chk("refill_one_cycle", flags(), 32'h0);

      cp0_entryhi = 32'h0040_0005;
      wr(3, 32'h0040_0005, 32'h0000_0106, 32'h0000_0142);
      data_req = 1'b1; data_we = 1'b1; data_vaddr = 32'h0040_1010; data_pc = 32'h0000_3000;
      tick(); data_req = 1'b0;
      chk("store_modify_flags", flags(), 32'h1);
      chk("store_modify_paddr", data_paddr, 32'h0000_5010);
      chk("store_modify_pc", tlbexc_pc, 32'h0000_3000);
      wr(3, 32'h0040_0005, 32'h0000_0106, 32'h0000_0140);
      data_req = 1'b1;
      tick(); data_req = 1'b0; data_we = 1'b0;
      chk("store_invalid_flags", flags(), 32'h2);

      wr(5, 32'h0080_0009, 32'h0000_0207, 32'h0000_0257);
      cp0_index = 5; tlbr_en = 1'b1; cp0_entryhi = 32'h0040_0006;
      data_req = 1'b1; data_vaddr = 32'h0080_0abc;
      tick(); tlbr_en = 1'b0;
      chk("global_read_lo0", tlb_entrylo0, 32'h0000_0207);
      chk("global_read_lo1", tlb_entrylo1, 32'h0000_0257);
      chk("global_paddr", data_paddr, 32'h0000_8abc);
      chk("global_flags", flags(), 32'h0);
      data_vaddr = 32'h0080_1004;
      tick();
      chk("mapped_c2_paddr", data_paddr, 32'h0000_9004);
      chk("mapped_c2_uncached", {31'b0, data_uncached}, 32'h1);

      inst_req = 1'b1; inst_vaddr = 32'hbfc0_0000; data_vaddr = 32'ha000_0010;
      tick();
      chk("kseg1_inst_paddr", inst_paddr, 32'h1fc0_0000);
      chk("kseg1_data_paddr", data_paddr, 32'h0000_0010);
      chk("kseg1_uncached", {31'b0, data_uncached}, 32'h1);
      chk("kseg1_flags", flags(), 32'h0);
      inst_vaddr = 32'h00c0_0000; data_vaddr = 32'h8000_1234;
      tick();
      chk("kseg0_data_paddr", data_paddr, 32'h0000_1234);
      chk("kseg0_uncached", {31'b0, data_uncached}, 32'h0);
      chk("inst_miss_flags", flags(), 32'h10);

      inst_req = 1'b0; data_vaddr = 32'h0000_0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midop_reset_flags", flags(), 32'h0);
      chk("midop_reset_index", tlb_index, 32'h0);
      chk("midop_reset_pc", tlbexc_pc, 32'h0);

      cp0_entryhi = 32'h0040_0005; cp0_index = 3; cp0_entrylo0 = 32'h0000_0106; cp0_entrylo1 = 32'h0000_0146;
      tlbwi_en = 1'b1; data_req = 1'b1; data_vaddr = 32'h0040_0123;
      tick(); tlbwi_en = 1'b0;
      chk("same_cycle_write_miss", flags(), 32'h4);
      tick();
      chk("next_cycle_hit_flags", flags(), 32'h0);
      chk("next_cycle_hit_paddr", data_paddr, 32'h0000_4123);
      inst_req = 1'b1; inst_vaddr = 32'h0040_0200; data_vaddr = 32'h0040_0300;
      tick(); inst_req = 1'b0; data_req = 1'b0;
      chk("dual_inst_paddr", inst_paddr, 32'h0000_4200);
      chk("dual_data_paddr", data_paddr, 32'h0000_4300);
      chk("dual_flags", flags(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
